// File: rtl/mrsc_pkg.sv
// mrsc_pkg: constants and helpers shared by the MRSC encoder and decoder.
//
// The 16-bit data word is viewed as a 4x4 bit matrix. Row i occupies four
// data bits; each row splits into a high pair [3:2] and a low pair [1:0].
// The 16 check bits hold four 2-bit row sums (DI) in the upper byte and
// four 2-bit cross-row XOR pairs (XA/XB) in the lower byte.
package mrsc_pkg;

  localparam int MRSC_DATA_W  = 16;
  localparam int MRSC_CHECK_W = 16;
  localparam int MRSC_CODE_W  = 32;
  localparam int MRSC_ROWS    = 4;
  localparam int MRSC_ROW_W   = 4;

  // Row positions inside the data word (LSB of each 4-bit row).
  localparam int ROW1_LSB = 12;
  localparam int ROW2_LSB = 8;
  localparam int ROW3_LSB = 4;
  localparam int ROW4_LSB = 0;

  // Check field offsets (LSB of each 2-bit field inside check[15:0]).
  localparam int DI1_LSB  = 14;
  localparam int DI2_LSB  = 12;
  localparam int DI3_LSB  = 10;
  localparam int DI4_LSB  = 8;
  localparam int XA13_LSB = 6;
  localparam int XB13_LSB = 4;
  localparam int XA24_LSB = 2;
  localparam int XB24_LSB = 0;

  // Data sits above the checks in the codeword.
  localparam int CODE_DATA_LSB = MRSC_CHECK_W;

  // 2-bit sum modulo 4: the carry out of the pair addition is dropped so
  // that every DI field stays exactly two bits wide.
  function automatic logic [1:0] mod4_sum(input logic [1:0] a,
                                          input logic [1:0] b);
    logic [2:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[1:0];
  endfunction

  // Decimal-integrity value of one 4-bit row: high pair plus low pair.
  function automatic logic [1:0] row_di(input logic [MRSC_ROW_W-1:0] row);
    return mod4_sum(row[3:2], row[1:0]);
  endfunction

endpackage

// File: rtl/mrsc_check_gen.sv
// mrsc_check_gen: purely combinational MRSC check-bit generator.
//
// Ports:
//   in_word [15:0]  data word, rows R1..R4 from MSB nibble down
//   check   [15:0]  {DI_1, DI_2, DI_3, DI_4, XA_1_3, XB_1_3, XA_2_4, XB_2_4}
//
// The decoder feeds the stored data half through this same block and
// compares against the stored check half to form a syndrome, so the field
// layout here is the single source of truth for both directions.
module mrsc_check_gen
  import mrsc_pkg::*;
(
  input  logic [MRSC_DATA_W-1:0]  in_word,
  output logic [MRSC_CHECK_W-1:0] check
);

  logic [MRSC_ROW_W-1:0] row1;
  logic [MRSC_ROW_W-1:0] row2;
  logic [MRSC_ROW_W-1:0] row3;
  logic [MRSC_ROW_W-1:0] row4;

  assign row1 = in_word[ROW1_LSB +: MRSC_ROW_W];
  assign row2 = in_word[ROW2_LSB +: MRSC_ROW_W];
  assign row3 = in_word[ROW3_LSB +: MRSC_ROW_W];
  assign row4 = in_word[ROW4_LSB +: MRSC_ROW_W];

  // Row sums form check column 2 of the matrix view.
  assign check[DI1_LSB +: 2] = row_di(row1);
  assign check[DI2_LSB +: 2] = row_di(row2);
  assign check[DI3_LSB +: 2] = row_di(row3);
  assign check[DI4_LSB +: 2] = row_di(row4);

  // Cross-row XORs pair row 1 with row 3 and row 2 with row 4, separately
  // for the high (A) and low (B) halves of each row.
  assign check[XA13_LSB +: 2] = row1[3:2] ^ row3[3:2];
  assign check[XB13_LSB +: 2] = row1[1:0] ^ row3[1:0];
  assign check[XA24_LSB +: 2] = row2[3:2] ^ row4[3:2];
  assign check[XB24_LSB +: 2] = row2[1:0] ^ row4[1:0];

endmodule

// File: rtl/mrsc_encoder.sv
// mrsc_encoder: registered MRSC encoder for 16-bit memory words.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset; clears codeword and valid
//   in_valid      in_word is valid this cycle
//   in_word[15:0] data word to encode
//   out_valid     encoded_word holds a fresh codeword (one cycle after input)
//   encoded_word[31:0] {in_word, check[15:0]}
//
// Single-cycle latency, one word per cycle, no backpressure. The codeword
// register only loads on a valid input, so it holds the last codeword
// through idle cycles. A word presented during reset is dropped.
module mrsc_encoder
  import mrsc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [MRSC_DATA_W-1:0] in_word,
  output logic                   out_valid,
  output logic [MRSC_CODE_W-1:0] encoded_word
);

  logic [MRSC_CHECK_W-1:0] check_p0;
  logic [MRSC_CODE_W-1:0]  code_p0;
  logic [MRSC_CODE_W-1:0]  code_p1;
  logic                    vld_p1;

  mrsc_check_gen u_check_gen (
    .in_word (in_word),
    .check   (check_p0)
  );

  assign code_p0 = {in_word, check_p0};

  // ---- stage p0 -> p1: output register ----
  // The codeword is cleared on reset as well, so every output bit is
  // defined from the first reset onward.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      code_p1 <= '0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        code_p1 <= code_p0;
      end
    end
  end

  assign out_valid    = vld_p1;
  assign encoded_word = code_p1;

endmodule

// File: tb/tb_mrsc_encoder.sv
module tb_mrsc_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_word;
  logic        out_valid;
  logic [31:0] encoded_word;
  logic [15:0] dec_check;

  int total;
  int bad;

  mrsc_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_word      (in_word),
    .out_valid    (out_valid),
    .encoded_word (encoded_word)
  );

  // Decoder-side recomputation of the checks from the stored data half.
  mrsc_check_gen u_dec (
    .in_word (encoded_word[31:16]),
    .check   (dec_check)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent reference: integer arithmetic on nibbles.
  function automatic logic [31:0] ref_code(input logic [15:0] w);
    logic [15:0] c;
    logic [3:0]  r [4];
    int          h;
    int          l;
    for (int i = 0; i < 4; i++) r[i] = w[15-4*i -: 4];
    for (int i = 0; i < 4; i++) begin
      h = int'(r[i]) / 4;
      l = int'(r[i]) % 4;
      c[15-2*i -: 2] = 2'((h + l) % 4);
    end
    c[7:6] = 2'((int'(r[0]) / 4) ^ (int'(r[2]) / 4));
    c[5:4] = 2'((int'(r[0]) % 4) ^ (int'(r[2]) % 4));
    c[3:2] = 2'((int'(r[1]) / 4) ^ (int'(r[3]) / 4));
    c[1:0] = 2'((int'(r[1]) % 4) ^ (int'(r[3]) % 4));
    return {w, c};
  endfunction

  task automatic step(input logic v, input logic [15:0] w);
    in_valid = v;
    in_word  = w;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'hFFFF);
      total++;
      if (encoded_word !== 32'h0) begin
        bad++;
        $display("FAIL reset_code cyc%0d: got %h want %h", i, encoded_word, 32'h0);
      end
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_valid cyc%0d: got %b want 0", i, out_valid);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_vectors;
    logic [15:0] words [5];
    logic [31:0] exps  [5];
    words = '{16'h80FA, 16'h0000, 16'h00FF, 16'h0400, 16'hFFFF};
    exps  = '{32'h80FA_887A, 32'h0000_0000, 32'h00FF_0AFF,
              32'h0400_1004, 32'hFFFF_AA00};
    for (int i = 0; i < 5; i++) begin
      step(1'b1, words[i]);
      total++;
      if (encoded_word !== exps[i]) begin
        bad++;
        $display("FAIL vec_code %h: got %h want %h", words[i], encoded_word, exps[i]);
      end
      total++;
      if (out_valid !== 1'b1) begin
        bad++;
        $display("FAIL vec_valid %h: got %b want 1", words[i], out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] words [3];
    logic [31:0] exps  [3];
    words = '{16'h80FA, 16'h00FF, 16'h0400};
    exps  = '{32'h80FA_887A, 32'h00FF_0AFF, 32'h0400_1004};
    step(1'b0, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, words[i]);
      total++;
      if (encoded_word !== exps[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d: got %h/%b want %h/1", i, encoded_word, out_valid, exps[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 16'hA5A5);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle_valid_%0d: got %b want 0", i, out_valid);
      end
      total++;
      if (encoded_word !== 32'h0400_1004) begin
        bad++;
        $display("FAIL idle_hold_%0d: got %h want %h", i, encoded_word, 32'h0400_1004);
      end
    end
  endtask

  task automatic test_reset_drop;
    rst = 1'b1;
    step(1'b1, 16'h80FA);
    rst = 1'b0;
    total++;
    if (encoded_word !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_prio: got %h/%b want 00000000/0", encoded_word, out_valid);
    end
    step(1'b0, 16'h80FA);
    total++;
    if (encoded_word !== 32'h0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_drop: got %h/%b want 00000000/0", encoded_word, out_valid);
    end
  endtask

  task automatic test_random;
    logic [15:0] w;
    logic [31:0] exp;
    for (int i = 0; i < 1000; i++) begin
      w   = 16'($urandom);
      exp = ref_code(w);
      step(1'b1, w);
      total++;
      if (encoded_word !== exp || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL rand_code %h: got %h/%b want %h/1", w, encoded_word, out_valid, exp);
      end
      total++;
      if (dec_check !== exp[15:0]) begin
        bad++;
        $display("FAIL rand_decode %h: got %h want %h", w, dec_check, exp[15:0]);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_word  = 16'h0;
    test_reset;
    test_vectors;
    test_back_to_back;
    test_reset_drop;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
